// File: rtl/bldc_motion_sequencer_if.sv
// Command channel into the BLDC motion sequencer.
// A command transfers on a sys_clk edge where cmd_valid and cmd_ready are both high;
// the master holds cmd_dir/cmd_duty stable while cmd_valid is high and not yet accepted.
interface bldc_motion_sequencer_if #(
  parameter int DW = 11
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_dir;
  logic [DW-1:0] cmd_duty;

  modport master (output cmd_valid, output cmd_dir, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/bldc_motion_sequencer.sv
// Command-level BLDC controller: slews driver duty toward a target, sequences
// direction reversals through ramp-down / coast / stop-wait, and latches driver faults.
module bldc_motion_sequencer #(
  parameter int clk_freq_hz         = 54_000_000,
  parameter int pwm_counter_width   = 11,
  parameter int counter_width       = 32,
  parameter int max_duty            = 1000,
  parameter int ramp_step           = 8,
  parameter int ramp_period_us      = 10,
  parameter int stop_rpm            = 30,
  parameter int stop_timeout_cycles = 54_000_000
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  bldc_motion_sequencer_if.slave       cmd,
  input  logic [counter_width-1:0]     rpm,
  input  logic [2:0]                   driver_state,
  input  logic                         fault_clear,
  output logic                         drv_enable,
  output logic [1:0]                   drv_direction,
  output logic [pwm_counter_width-1:0] drv_duty,
  output logic [2:0]                   state,
  output logic                         stop_timeout
);

  localparam int DW      = pwm_counter_width;
  localparam int TICK_P  = clk_freq_hz / 1_000_000 * ramp_period_us;
  localparam int TICK_W  = $clog2(TICK_P + 1);
  localparam int TO_W    = $clog2(stop_timeout_cycles + 1);

  localparam logic [TICK_W-1:0]        TICK_LAST = TICK_W'(TICK_P - 1);
  localparam logic [TO_W-1:0]          TO_LAST   = TO_W'(stop_timeout_cycles - 1);
  localparam logic [DW-1:0]            MAX_D     = DW'(max_duty);
  localparam logic [DW-1:0]            STEP_D    = DW'(ramp_step);
  localparam logic [counter_width-1:0] STOP_RPM  = counter_width'(stop_rpm);
  localparam logic [2:0]               DRV_ERR   = 3'd3;
  localparam logic [1:0]               DIR_NONE  = 2'd0;
  localparam logic [1:0]               DIR_CW    = 2'd1;
  localparam logic [1:0]               DIR_CCW   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_HOLD      = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_WAIT_STOP = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                en_q, en_d;
  logic [1:0]          dir_q, dir_d;
  logic [DW-1:0]       duty_q, duty_d;
  logic [DW-1:0]       target_q, target_d;
  logic                pend_v_q, pend_v_d;
  logic [1:0]          pend_dir_q, pend_dir_d;
  logic [DW-1:0]       pend_duty_q, pend_duty_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                stop_seen_q, stop_seen_d;
  logic                timeout_q, timeout_d;

  logic                cmd_ready_w;
  logic                tick;
  logic                accept;
  logic                cmd_stop;
  logic [DW-1:0]       duty_c;
  logic                run_upd;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      dir_q       <= DIR_NONE;
      duty_q      <= '0;
      target_q    <= '0;
      pend_v_q    <= 1'b0;
      pend_dir_q  <= DIR_NONE;
      pend_duty_q <= '0;
      tick_cnt_q  <= '0;
      to_cnt_q    <= '0;
      stop_seen_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      dir_q       <= dir_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      pend_v_q    <= pend_v_d;
      pend_dir_q  <= pend_dir_d;
      pend_duty_q <= pend_duty_d;
      tick_cnt_q  <= tick_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stop_seen_q <= stop_seen_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    dir_d       = dir_q;
    duty_d      = duty_q;
    target_d    = target_q;
    pend_v_d    = pend_v_q;
    pend_dir_d  = pend_dir_q;
    pend_duty_d = pend_duty_q;
    timeout_d   = timeout_q;
    to_cnt_d    = '0;
    stop_seen_d = 1'b0;
    run_upd     = 1'b0;

    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    accept   = cmd.cmd_valid && cmd_ready_w;
    cmd_stop = !(cmd.cmd_dir == DIR_CW || cmd.cmd_dir == DIR_CCW) || (cmd.cmd_duty == '0);
    duty_c   = (cmd.cmd_duty > MAX_D) ? MAX_D : cmd.cmd_duty;

    if (driver_state == DRV_ERR && state_q != S_FAULT) begin
      state_d     = S_FAULT;
      en_d        = 1'b0;
      dir_d       = DIR_NONE;
      duty_d      = '0;
      target_d    = '0;
      pend_v_d    = 1'b0;
      pend_dir_d  = DIR_NONE;
      pend_duty_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) timeout_d = 1'b0;
          if (accept && !cmd_stop) begin
            dir_d    = cmd.cmd_dir;
            en_d     = 1'b1;
            target_d = duty_c;
            run_upd  = 1'b1;
          end
        end
        S_RAMP_UP, S_HOLD, S_RAMP_DOWN: begin
          if (accept) begin
            timeout_d = 1'b0;
            run_upd   = 1'b1;
            if (!cmd_stop && cmd.cmd_dir == dir_q) begin
              target_d = duty_c;
              pend_v_d = 1'b0;
            end else begin
              // Reversal or stop: remember where to go once the rotor is at rest.
              pend_v_d    = 1'b1;
              pend_dir_d  = cmd_stop ? DIR_NONE : cmd.cmd_dir;
              pend_duty_d = cmd_stop ? '0 : duty_c;
              target_d    = '0;
            end
          end else if (pend_v_q && duty_q == '0) begin
            en_d    = 1'b0;
            state_d = S_WAIT_STOP;
          end else begin
            run_upd = 1'b1;
          end
        end
        S_WAIT_STOP: begin
          to_cnt_d    = to_cnt_q + 1'b1;
          stop_seen_d = (rpm < STOP_RPM);
          if (stop_seen_q || to_cnt_q == TO_LAST) begin
            if (!stop_seen_q) timeout_d = 1'b1;
            to_cnt_d    = '0;
            stop_seen_d = 1'b0;
            pend_v_d    = 1'b0;
            if (pend_v_q && pend_dir_q != DIR_NONE) begin
              dir_d    = pend_dir_q;
              en_d     = 1'b1;
              target_d = pend_duty_q;
              state_d  = S_RAMP_UP;
            end else begin
              dir_d   = DIR_NONE;
              state_d = S_IDLE;
            end
          end
        end
        S_FAULT: begin
          if (fault_clear && driver_state != DRV_ERR) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The slew step sees any target written above in the same cycle.
    if (run_upd) begin
      if (tick) begin
        if (duty_d < target_d)
          duty_d = (target_d - duty_d > STEP_D) ? duty_d + STEP_D : target_d;
        else if (duty_d > target_d)
          duty_d = (duty_d - target_d > STEP_D) ? duty_d - STEP_D : target_d;
      end
      if (pend_v_d)                state_d = S_RAMP_DOWN;
      else if (duty_d < target_d)  state_d = S_RAMP_UP;
      else if (duty_d > target_d)  state_d = S_RAMP_DOWN;
      else                         state_d = S_HOLD;
    end
  end

  always_comb begin
    cmd_ready_w = 1'b0;
    if ((state_q == S_IDLE || state_q == S_RAMP_UP || state_q == S_HOLD ||
         state_q == S_RAMP_DOWN) && driver_state != DRV_ERR)
      cmd_ready_w = 1'b1;
  end

  assign cmd.cmd_ready   = cmd_ready_w;
  assign drv_enable      = en_q;
  assign drv_direction   = dir_q;
  assign drv_duty        = duty_q;
  assign state           = state_q;
  assign stop_timeout    = timeout_q;

endmodule
